// File: rtl/gpr_operand_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpr_operand_reader                                           |
// | Description : GPR array, busy scoreboard and decode->execute operand       |
// |               register with same-cycle writeback bypass and hazard stall.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gpr_operand_reader #(
  parameter int XLEN     = 64,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rs1,
  input  logic [ADDR_W-1:0] iss_rs2,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rd_we,
  output logic              iss_ready,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [ADDR_W-1:0] ex_rd,
  output logic              ex_rd_we
);

  // Register 0 is hardwired to zero, so neither storage nor a busy bit exists for it.
  logic [XLEN-1:0]     r_gpr [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] r_busy;

  logic                r_ex_valid;
  logic [XLEN-1:0]     r_ex_rs1_val;
  logic [XLEN-1:0]     r_ex_rs2_val;
  logic [ADDR_W-1:0]   r_ex_rd;
  logic                r_ex_rd_we;

  logic [NUM_REGS-1:1] w_wb_hit;
  logic [NUM_REGS-1:1] w_busy_set;

  logic                w_rs1_in;
  logic                w_rs2_in;
  logic [XLEN-1:0]     w_rs1_gpr;
  logic [XLEN-1:0]     w_rs2_gpr;
  logic                w_rs1_busy;
  logic                w_rs2_busy;
  logic                w_rd_busy;

  logic                w_rs1_byp;
  logic                w_rs2_byp;
  logic                w_rd_byp;
  logic [XLEN-1:0]     w_rs1_val;
  logic [XLEN-1:0]     w_rs2_val;

  logic                w_rs1_hz;
  logic                w_rs2_hz;
  logic                w_rd_hz;
  logic                w_hazard;
  logic                w_accept;

  // Per-register write and scoreboard-set decode.
  generate
    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg_dec
      assign w_wb_hit[gi]   = wb_valid && (wb_rd == ADDR_W'(gi));
      assign w_busy_set[gi] = w_accept && iss_rd_we && (iss_rd == ADDR_W'(gi));
    end
  endgenerate

  // Index match loops leave index 0 and out-of-range indices at zero / not busy.
  always_comb begin
    w_rs1_in   = 1'b0;
    w_rs2_in   = 1'b0;
    w_rs1_gpr  = '0;
    w_rs2_gpr  = '0;
    w_rs1_busy = 1'b0;
    w_rs2_busy = 1'b0;
    w_rd_busy  = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (iss_rs1 == ADDR_W'(i)) begin
        w_rs1_in   = 1'b1;
        w_rs1_gpr  = r_gpr[i];
        w_rs1_busy = r_busy[i];
      end
      if (iss_rs2 == ADDR_W'(i)) begin
        w_rs2_in   = 1'b1;
        w_rs2_gpr  = r_gpr[i];
        w_rs2_busy = r_busy[i];
      end
      if (iss_rd == ADDR_W'(i)) begin
        w_rd_busy  = r_busy[i];
      end
    end
  end

  assign w_rs1_byp = wb_valid && (wb_rd == iss_rs1);
  assign w_rs2_byp = wb_valid && (wb_rd == iss_rs2);
  assign w_rd_byp  = wb_valid && (wb_rd == iss_rd);

  assign w_rs1_val = (w_rs1_in && w_rs1_byp) ? wb_data : w_rs1_gpr;
  assign w_rs2_val = (w_rs2_in && w_rs2_byp) ? wb_data : w_rs2_gpr;

  // A producer completing this cycle resolves its own hazard.
  assign w_rs1_hz  = w_rs1_busy && !w_rs1_byp;
  assign w_rs2_hz  = w_rs2_busy && !w_rs2_byp;
  assign w_rd_hz   = w_rd_busy  && !w_rd_byp;
  assign w_hazard  = w_rs1_hz || w_rs2_hz || (iss_rd_we && w_rd_hz);

  assign iss_ready = !w_hazard && (!r_ex_valid || ex_ready);
  assign w_accept  = iss_valid && iss_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        r_gpr[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wb_hit[i]) begin
          r_gpr[i] <= wb_data;
        end
      end
    end
  end

  // Set has priority: a new producer claiming r owns it even as the old one retires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_busy_set[i]) begin
          r_busy[i] <= 1'b1;
        end else if (w_wb_hit[i]) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_valid   <= 1'b0;
      r_ex_rs1_val <= '0;
      r_ex_rs2_val <= '0;
      r_ex_rd      <= '0;
      r_ex_rd_we   <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid   <= 1'b1;
      r_ex_rs1_val <= w_rs1_val;
      r_ex_rs2_val <= w_rs2_val;
      r_ex_rd      <= iss_rd;
      r_ex_rd_we   <= iss_rd_we;
    end else if (ex_ready) begin
      r_ex_valid   <= 1'b0;
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_rs1_val = r_ex_rs1_val;
  assign ex_rs2_val = r_ex_rs2_val;
  assign ex_rd      = r_ex_rd;
  assign ex_rd_we   = r_ex_rd_we;

endmodule
`default_nettype wire

// File: tb/tb_gpr_operand_reader.sv
`default_nettype none
// Directed testbench for gpr_operand_reader: expected execute-stage transactions
// are queued by the stimulus and checked by an independent monitor.
module tb_gpr_operand_reader;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [63:0] wb_data;
  logic        iss_valid;
  logic [5:0]  iss_rs1;
  logic [5:0]  iss_rs2;
  logic [5:0]  iss_rd;
  logic        iss_rd_we;
  logic        iss_ready;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_rs1_val;
  logic [63:0] ex_rs2_val;
  logic [5:0]  ex_rd;
  logic        ex_rd_we;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [5:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  gpr_operand_reader #(.XLEN(64), .NUM_REGS(32), .ADDR_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_rd_we (iss_rd_we),
    .iss_ready (iss_ready),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rs1_val(ex_rs1_val),
    .ex_rs2_val(ex_rs2_val),
    .ex_rd     (ex_rd),
    .ex_rd_we  (ex_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] rs1, input logic [5:0] rs2,
                       input logic [5:0] rd, input logic we);
    iss_valid = 1'b1;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
    iss_rd    = rd;
    iss_rd_we = we;
  endtask

  task automatic wb(input logic v, input logic [5:0] rd, input logic [63:0] data);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = data;
  endtask

  task automatic expect_ready(input string name, input logic req);
    #2;
    chk(name, 64'(iss_ready), 64'(req));
  endtask

  task automatic push(input logic [63:0] rs1, input logic [63:0] rs2,
                      input logic [5:0] rd, input logic we);
    exp_q.push_back('{rs1: rs1, rs2: rs2, rd: rd, we: we});
  endtask

  // Monitor: every consumed execute transaction must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ex_unexpected: got rs1=%h rd=%0d, required no transaction",
                   ex_rs1_val, ex_rd);
        end else begin
          e = exp_q.pop_front();
          chk("ex_rs1_val", ex_rs1_val, e.rs1);
          chk("ex_rs2_val", ex_rs2_val, e.rs2);
          chk("ex_rd", 64'(ex_rd), 64'(e.rd));
          chk("ex_rd_we", 64'(ex_rd_we), 64'(e.we));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b0;
    ex_ready = 1'b1;
    wb(1'b0, 6'd0, 64'd0);
    // Issue presented during reset must not set busy[9].
    drive(6'd0, 6'd0, 6'd9, 1'b1);
    tick();
    tick();
    chk("reset_ex_valid", 64'(ex_valid), 64'd0);
    chk("reset_ex_rs1", ex_rs1_val, 64'd0);
    chk("reset_ex_rs2", ex_rs2_val, 64'd0);
    chk("reset_ex_rd", 64'(ex_rd), 64'd0);
    chk("reset_ex_rd_we", 64'(ex_rd_we), 64'd0);
    reset = 1'b1;

    // Zero register reads and no stale busy from the reset-time issue.
    drive(6'd9, 6'd0, 6'd1, 1'b0);
    expect_ready("t1_ready", 1'b1);
    push(64'd0, 64'd0, 6'd1, 1'b0);
    tick();
    chk("t1_latency", 64'(ex_valid), 64'd1);

    // Same-cycle writeback bypass; rd=0 with we must not mark busy.
    wb(1'b1, 6'd5, 64'hDEAD_BEEF);
    drive(6'd5, 6'd5, 6'd0, 1'b1);
    expect_ready("t2_ready", 1'b1);
    push(64'hDEAD_BEEF, 64'hDEAD_BEEF, 6'd0, 1'b1);
    tick();
    wb(1'b0, 6'd0, 64'd0);

    // Stored value read back; rd=7 becomes busy.
    drive(6'd5, 6'd0, 6'd7, 1'b1);
    expect_ready("t3_ready", 1'b1);
    push(64'hDEAD_BEEF, 64'd0, 6'd7, 1'b1);
    tick();

    // RAW on rs2=7 until its writeback arrives.
    drive(6'd0, 6'd7, 6'd0, 1'b0);
    expect_ready("t4_raw_stall0", 1'b0);
    tick();
    expect_ready("t4_raw_stall1", 1'b0);
    tick();
    wb(1'b1, 6'd7, 64'd42);
    expect_ready("t4_raw_release", 1'b1);
    push(64'd0, 64'd42, 6'd0, 1'b0);
    tick();
    wb(1'b0, 6'd0, 64'd0);

    // WAW on rd=3; reissue while retiring keeps busy[3].
    drive(6'd0, 6'd0, 6'd3, 1'b1);
    expect_ready("t5_first_rd3", 1'b1);
    push(64'd0, 64'd0, 6'd3, 1'b1);
    tick();
    expect_ready("t5_waw_stall", 1'b0);
    tick();
    wb(1'b1, 6'd3, 64'd33);
    expect_ready("t5_waw_release", 1'b1);
    push(64'd0, 64'd0, 6'd3, 1'b1);
    tick();
    wb(1'b0, 6'd0, 64'd0);
    drive(6'd3, 6'd3, 6'd0, 1'b0);
    expect_ready("t5_busy_kept", 1'b0);
    tick();
    wb(1'b1, 6'd3, 64'd77);
    expect_ready("t5_busy_release", 1'b1);
    push(64'd77, 64'd77, 6'd0, 1'b0);
    tick();

    // Writes to r0 ignored and r0 never goes busy.
    wb(1'b1, 6'd0, 64'd1);
    drive(6'd0, 6'd0, 6'd0, 1'b1);
    expect_ready("t6_r0_ready", 1'b1);
    push(64'd0, 64'd0, 6'd0, 1'b1);
    tick();
    wb(1'b0, 6'd0, 64'd0);
    expect_ready("t6_r0_not_busy", 1'b1);
    push(64'd0, 64'd0, 6'd0, 1'b1);
    tick();

    // Out-of-range index reads zero, even with a matching writeback.
    wb(1'b1, 6'd40, 64'd123);
    drive(6'd40, 6'd40, 6'd0, 1'b0);
    expect_ready("t6_oor_ready", 1'b1);
    push(64'd0, 64'd0, 6'd0, 1'b0);
    tick();
    wb(1'b0, 6'd0, 64'd0);

    iss_valid = 1'b0;
    tick();
    chk("drain_valid", 64'(ex_valid), 64'd0);

    // Hold under back-pressure, then back-to-back with no bubble.
    ex_ready = 1'b0;
    drive(6'd5, 6'd3, 6'd2, 1'b0);
    expect_ready("t7_accept_a", 1'b1);
    push(64'hDEAD_BEEF, 64'd77, 6'd2, 1'b0);
    tick();
    drive(6'd7, 6'd0, 6'd4, 1'b1);
    for (int c = 0; c < 3; c++) begin
      expect_ready("t7_hold_ready", 1'b0);
      chk("t7_hold_valid", 64'(ex_valid), 64'd1);
      chk("t7_hold_rs1", ex_rs1_val, 64'hDEAD_BEEF);
      chk("t7_hold_rd", 64'(ex_rd), 64'd2);
      tick();
    end
    ex_ready = 1'b1;
    expect_ready("t7_b2b_ready", 1'b1);
    push(64'd42, 64'd0, 6'd4, 1'b1);
    tick();
    chk("t7_no_bubble", 64'(ex_valid), 64'd1);
    chk("t7_new_rs1", ex_rs1_val, 64'd42);
    iss_valid = 1'b0;
    tick();
    chk("t7_drained", 64'(ex_valid), 64'd0);
    chk("t7_drain_keeps", ex_rs1_val, 64'd42);

    // Reset mid-operation discards ex contents, busy bits and GPRs.
    ex_ready = 1'b0;
    drive(6'd5, 6'd0, 6'd9, 1'b1);
    tick();
    chk("t8_inflight", 64'(ex_valid), 64'd1);
    iss_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("t8_reset_valid", 64'(ex_valid), 64'd0);
    chk("t8_reset_rs1", ex_rs1_val, 64'd0);
    reset    = 1'b1;
    ex_ready = 1'b1;
    drive(6'd9, 6'd4, 6'd0, 1'b0);
    expect_ready("t8_busy_cleared", 1'b1);
    push(64'd0, 64'd0, 6'd0, 1'b0);
    tick();
    drive(6'd5, 6'd7, 6'd0, 1'b0);
    expect_ready("t8_gpr_ready", 1'b1);
    push(64'd0, 64'd0, 6'd0, 1'b0);
    tick();
    iss_valid = 1'b0;
    tick();
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
